// File: rtl/onewire_slave_core.sv
// 1-wire slave front end: reset/presence handling, write-slot decode and
// read-slot drive between the open-drain DQ pad and the command logic.
module onewire_slave_core #(
  parameter int CLKS_PER_US  = 50,
  parameter int RST_MIN_US   = 480,
  parameter int RST_MAX_US   = 1000,
  parameter int PRES_WAIT_US = 60,
  parameter int PRES_LEN_US  = 240,
  parameter int SAMPLE_US    = 30,
  parameter int TX_HOLD_US   = 30,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       bus_reset,
  output logic       presence_done,
  output logic       bus_fault,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [2:0] bit_cnt
);

  localparam int MIN_CNT  = RST_MIN_US * CLKS_PER_US;
  localparam int MAX_CNT  = RST_MAX_US * CLKS_PER_US;
  localparam int WAIT_CNT = PRES_WAIT_US * CLKS_PER_US;
  localparam int LEN_CNT  = PRES_LEN_US * CLKS_PER_US;
  localparam int SMP_CNT  = SAMPLE_US * CLKS_PER_US;
  localparam int HOLD_CNT = TX_HOLD_US * CLKS_PER_US;
  localparam int LOW_SAT  = MAX_CNT + 1;
  localparam int LOW_W    = $clog2(LOW_SAT + 1);
  localparam int T1       = (LEN_CNT > WAIT_CNT) ? LEN_CNT : WAIT_CNT;
  localparam int T2       = (HOLD_CNT > SMP_CNT + 1) ? HOLD_CNT : SMP_CNT + 1;
  localparam int TMR_MAX  = (T1 > T2) ? T1 : T2;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam int BLK_W    = $clog2(SYNC_STAGES + 2);

  typedef enum logic [2:0] {
    IDLE,
    PRES_WAIT,
    PRES_DRIVE,
    SLOT_IDLE,
    SLOT_ACT
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync;
  logic                   dq_s;
  logic                   dq_s_d;
  logic                   rise;
  logic                   fall;
  logic [LOW_W-1:0]       low_cnt;
  logic [BLK_W-1:0]       blank_cnt;
  logic                   blank;
  logic                   low_run;
  logic [TMR_W-1:0]       tmr;
  logic [7:0]             sr;
  logic [7:0]             tx_sr;
  logic                   tx_full;

  logic do_reset;
  logic do_fault;
  logic tmr_clr;
  logic do_shift;
  logic bit_done;
  logic byte_done;
  logic tx_accept;
  logic pres_end;

  function automatic logic [LOW_W-1:0] low_inc(input logic [LOW_W-1:0] v);
    return (v == LOW_W'(LOW_SAT)) ? v : v + 1'b1;
  endfunction

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_W'(TMR_MAX)) ? v : v + 1'b1;
  endfunction

  assign dq_s    = sync[SYNC_STAGES-1];
  assign rise    = dq_s & ~dq_s_d;
  assign fall    = ~dq_s & dq_s_d;
  // Our own drive reads back through the synchroniser, so hide it from the low timer.
  assign blank   = dq_oe | (blank_cnt != '0);
  assign low_run = ~dq_s & ~blank;

  assign do_fault  = low_run && (low_cnt == LOW_W'(MAX_CNT));
  assign do_reset  = rise && (low_cnt >= LOW_W'(MIN_CNT)) && (low_cnt <= LOW_W'(MAX_CNT));
  assign byte_done = bit_done && (bit_cnt == 3'd7);
  assign tx_ready  = tx_accept;

  assign dq_oe = (state == PRES_DRIVE) ||
                 ((state == SLOT_ACT) && tx_full && !tx_sr[bit_cnt] &&
                  (tmr < TMR_W'(HOLD_CNT)));

  always_ff @(posedge clk or posedge rst_start) begin
    if (rst_start) state <= IDLE;
    else           state <= state_d;
  end

  always_comb begin
    state_d   = state;
    tmr_clr   = 1'b0;
    do_shift  = 1'b0;
    bit_done  = 1'b0;
    tx_accept = 1'b0;
    pres_end  = 1'b0;
    if (do_fault) begin
      state_d = IDLE;
    end else if (do_reset) begin
      state_d = PRES_WAIT;
      tmr_clr = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        PRES_WAIT: begin
          if (tmr == TMR_W'(WAIT_CNT - 1)) begin
            state_d = PRES_DRIVE;
            tmr_clr = 1'b1;
          end
        end
        PRES_DRIVE: begin
          if (tmr == TMR_W'(LEN_CNT - 1)) begin
            state_d  = SLOT_IDLE;
            pres_end = 1'b1;
          end
        end
        SLOT_IDLE: begin
          // A slot edge takes priority over loading a new tx byte.
          if (fall) begin
            state_d = SLOT_ACT;
            tmr_clr = 1'b1;
          end else if (tx_valid && (bit_cnt == 3'd0) && !tx_full) begin
            tx_accept = 1'b1;
          end
        end
        SLOT_ACT: begin
          if (!tx_full && (tmr == TMR_W'(SMP_CNT)))
            do_shift = 1'b1;
          // Write slots may end only once the bit has been sampled.
          if (dq_s && !blank && (tx_full || (tmr > TMR_W'(SMP_CNT)))) begin
            state_d  = SLOT_IDLE;
            bit_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_start) begin
    if (rst_start) begin
      sync          <= '1;
      dq_s_d        <= 1'b1;
      low_cnt       <= '0;
      blank_cnt     <= '0;
      tmr           <= '0;
      bit_cnt       <= 3'd0;
      tx_full       <= 1'b0;
      rx_data       <= 8'd0;
      rx_valid      <= 1'b0;
      tx_done       <= 1'b0;
      bus_reset     <= 1'b0;
      bus_fault     <= 1'b0;
      presence_done <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], dq_in};
      dq_s_d <= dq_s;

      if (blank || dq_s) low_cnt <= '0;
      else               low_cnt <= low_inc(low_cnt);

      if (dq_oe)                blank_cnt <= BLK_W'(SYNC_STAGES + 1);
      else if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;

      if (tmr_clr) tmr <= '0;
      else         tmr <= tmr_inc(tmr);

      if (do_fault || do_reset) bit_cnt <= 3'd0;
      else if (bit_done)        bit_cnt <= bit_cnt + 3'd1;

      if (do_fault || do_reset)       tx_full <= 1'b0;
      else if (tx_accept)             tx_full <= 1'b1;
      else if (byte_done && tx_full)  tx_full <= 1'b0;

      if (byte_done && !tx_full) rx_data <= sr;
      rx_valid      <= byte_done && !tx_full;
      tx_done       <= byte_done && tx_full;
      bus_reset     <= do_reset;
      bus_fault     <= do_fault;
      presence_done <= pres_end;
    end
  end

  always_ff @(posedge clk) begin
    if (do_shift)  sr    <= {dq_s, sr[7:1]};
    if (tx_accept) tx_sr <= tx_data;
  end

endmodule

// File: tb/tb_onewire_slave_core.sv
// Bench for onewire_slave_core: host-side bus model, reset-pulse vector table,
// and a byte scoreboard for write slots plus read-slot drive checks.
module tb_onewire_slave_core;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_start;
  logic       host_low;
  logic       dq_in;
  logic       dq_oe;
  logic       bus_reset;
  logic       presence_done;
  logic       bus_fault;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [2:0] bit_cnt;

  assign dq_in = !(host_low || dq_oe);

  onewire_slave_core #(.CLKS_PER_US(C)) dut (
    .clk(clk), .rst_start(rst_start), .dq_in(dq_in), .dq_oe(dq_oe),
    .bus_reset(bus_reset), .presence_done(presence_done), .bus_fault(bus_fault),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_reset = 0, n_fault = 0, n_pres = 0, n_txd = 0, n_txr = 0;
  int t_reset = 0, t_fault = 0, t_pres = 0, t_oe_rise = 0, t_oe_fall = 0;
  int run = 0;
  logic oe_prev = 1'b0;
  int oe_runs[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (bus_reset) begin n_reset++; t_reset = cyc; end
    if (bus_fault) begin n_fault++; t_fault = cyc; end
    if (presence_done) begin n_pres++; t_pres = cyc; end
    if (tx_done) n_txd++;
    if (tx_ready) n_txr++;
    if (dq_oe && !oe_prev) begin t_oe_rise = cyc; run = 0; end
    if (dq_oe) run++;
    if (!dq_oe && oe_prev) begin t_oe_fall = cyc; oe_runs.push_back(run); end
    oe_prev = dq_oe;
    if (rx_valid) got_q.push_back(rx_data);
  end

  int total = 0;
  int bad = 0;
  int gi = 0;
  logic [7:0] exp_q[$];
  int t_start_h = 0, t_rel_h = 0;

  typedef struct {
    int low_us;
    int exp_reset;
    int exp_fault;
    int exp_pres;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst_start = 1'b1;
    @(negedge clk);
    rst_start = 1'b0;
    @(posedge clk);
  endtask

  task automatic host_pulse(input int low_cyc);
    @(posedge clk);
    #1 host_low = 1'b1;
    t_start_h = cyc;
    repeat (low_cyc) @(posedge clk);
    #1 host_low = 1'b0;
    t_rel_h = cyc;
  endtask

  task automatic slot(input int low_cyc, input int total_cyc);
    host_pulse(low_cyc);
    repeat (total_cyc - low_cyc) @(posedge clk);
  endtask

  task automatic wait_pres(input int p0);
    int k;
    for (k = 0; k < 2000 * C && n_pres == p0; k++) @(negedge clk);
    if (n_pres == p0) chk("pres_timeout", 0, 1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) slot(b[i] ? 5 * C : 60 * C, 70 * C);
  endtask

  task automatic check_rx();
    int k;
    for (k = 0; k < 200 * C && got_q.size() <= gi; k++) @(negedge clk);
    if (got_q.size() <= gi) begin
      chk("rx_timeout", 0, 1);
    end else begin
      chk("rx_data", got_q[gi], exp_q.pop_front());
      gi++;
    end
  endtask

  initial begin
    int r0, f0, p0, o0, x0, d0, g0;
    logic [7:0] txb;

    vecs[0] = '{500, 1, 0, 1};
    vecs[1] = '{400, 0, 0, 0};
    vecs[2] = '{480, 1, 0, 1};
    vecs[3] = '{479, 0, 0, 0};
    vecs[4] = '{1000, 1, 0, 1};
    vecs[5] = '{1001, 0, 1, 0};
    vecs[6] = '{1200, 0, 1, 0};

    rst_start = 1'b1;
    host_low  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {bus_reset, bus_fault, presence_done, rx_valid, tx_done}, 0);
    rst_start = 1'b0;

    // Reset-pulse classification table
    for (int v = 0; v < 7; v++) begin
      do_rst();
      r0 = n_reset; f0 = n_fault; p0 = n_pres; o0 = oe_runs.size();
      host_pulse(vecs[v].low_us * C);
      repeat (350 * C) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_reset", vecs[v].low_us), n_reset - r0, vecs[v].exp_reset);
      chk($sformatf("v%0d_fault", vecs[v].low_us), n_fault - f0, vecs[v].exp_fault);
      chk($sformatf("v%0d_pres", vecs[v].low_us), n_pres - p0, vecs[v].exp_pres);
      chk($sformatf("v%0d_oe", vecs[v].low_us), (oe_runs.size() > o0) ? 1 : 0, vecs[v].exp_pres);
      chk($sformatf("v%0d_bitcnt", vecs[v].low_us), bit_cnt, 0);
    end

    // Presence timing, then a write byte
    do_rst();
    p0 = n_pres; o0 = oe_runs.size();
    host_pulse(500 * C);
    wait_pres(p0);
    chk_rng("reset_latency", t_reset - t_rel_h, 2, 3);
    chk("pres_delay", t_oe_rise - t_reset, 60 * C);
    chk("pres_len", (oe_runs.size() > o0) ? oe_runs[o0] : -1, 240 * C);
    chk("pres_done_at_release", t_pres, t_oe_fall);
    repeat (10 * C) @(posedge clk);
    g0 = got_q.size();
    write_byte(8'hCC);
    check_rx();
    chk("cc_single_valid", got_q.size() - g0, 1);

    // Read byte 0xA5, tx_valid held during the byte must be held off
    txb = 8'hA5;
    x0 = n_txr; d0 = n_txd; g0 = got_q.size();
    @(posedge clk);
    #1 tx_data = txb;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      o0 = oe_runs.size();
      if (i == 4) tx_valid = 1'b0;
      slot(2 * C, 70 * C);
      chk($sformatf("tx_drive_b%0d", i), oe_runs.size() - o0, txb[i] ? 0 : 1);
      if (oe_runs.size() > o0) chk($sformatf("tx_hold_b%0d", i), oe_runs[o0], 30 * C);
    end
    tx_valid = 1'b0;
    @(negedge clk);
    chk("tx_ready_once", n_txr - x0, 1);
    chk("tx_done_once", n_txd - d0, 1);
    chk("tx_no_rx_valid", got_q.size() - g0, 0);

    // Reset in the middle of a write byte
    g0 = got_q.size();
    slot(5 * C, 70 * C);
    slot(60 * C, 70 * C);
    slot(5 * C, 70 * C);
    @(negedge clk);
    chk("partial_bitcnt", bit_cnt, 3);
    p0 = n_pres;
    host_pulse(500 * C);
    wait_pres(p0);
    chk("abort_no_rx_valid", got_q.size() - g0, 0);
    chk("abort_bitcnt", bit_cnt, 0);
    chk("abort_presence", n_pres - p0, 1);
    repeat (10 * C) @(posedge clk);
    write_byte(8'h44);
    check_rx();

    // Bus fault timing
    do_rst();
    r0 = n_reset; f0 = n_fault; p0 = n_pres;
    host_pulse(1200 * C);
    repeat (350 * C) @(posedge clk);
    @(negedge clk);
    chk("fault_once", n_fault - f0, 1);
    chk_rng("fault_time", t_fault - t_start_h, 1000 * C, 1000 * C + 6);
    chk("fault_no_reset", n_reset - r0, 0);
    chk("fault_no_pres", n_pres - p0, 0);

    // Asynchronous reset during presence drive
    do_rst();
    host_pulse(500 * C);
    for (int k = 0; k < 200 * C && !dq_oe; k++) @(negedge clk);
    chk("drive_seen", dq_oe, 1);
    @(negedge clk);
    #2 rst_start = 1'b1;
    #1 chk("async_release", dq_oe, 0);
    @(negedge clk);
    rst_start = 1'b0;
    repeat (5) @(posedge clk);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
